// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480 scan sequencer.
// Defaults describe 640x480@60; the blocks are parameterised so other modes reuse them.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam logic        DEF_SYNC_POL = 1'b0;
    localparam int unsigned DEF_CW       = 10;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

    typedef enum logic {IDLE, SCAN} scan_state_t;

endpackage

// File: rtl/vga_axis_timing.sv
// One scan axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
// clr forces position 0 / ACTIVE; step advances one position.
module vga_axis_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned A_LEN = DEF_H_ACTIVE,
    parameter int unsigned F_LEN = DEF_H_FRONT,
    parameter int unsigned S_LEN = DEF_H_SYNC,
    parameter int unsigned B_LEN = DEF_H_BACK,
    parameter int unsigned CW    = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic [1:0]    phase,
    output logic          wrap,
    output logic          in_sync,
    output logic          in_active
);

    localparam int unsigned   TOTAL   = A_LEN + F_LEN + S_LEN + B_LEN;
    localparam logic [CW-1:0] F_START = CW'(A_LEN);
    localparam logic [CW-1:0] S_START = CW'(A_LEN + F_LEN);
    localparam logic [CW-1:0] B_START = CW'(A_LEN + F_LEN + S_LEN);
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    phase_t        phase_q, phase_d;
    logic          in_sync_q, in_active_q;

    assign wrap = (cnt_q == LAST);

    // Phase boundaries are detected on the count being loaded, so phase and count move together.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = ACTIVE;
        end else if (step) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
            unique case (phase_q)
                ACTIVE:  if (cnt_d == F_START) phase_d = FRONT;
                FRONT:   if (cnt_d == S_START) phase_d = SYNC;
                SYNC:    if (cnt_d == B_START) phase_d = BACK;
                BACK:    if (cnt_d == '0)      phase_d = ACTIVE;
                default: phase_d = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            phase_q     <= ACTIVE;
            in_sync_q   <= 1'b0;
            in_active_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            in_sync_q   <= (phase_d == SYNC);
            in_active_q <= (phase_d == ACTIVE);
        end
    end

    assign cnt       = cnt_q;
    assign phase     = phase_q;
    assign in_sync   = in_sync_q;
    assign in_active = in_active_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// Scan sequencer: IDLE/SCAN control over two axis timers, sync/blank outputs and
// frame/line marker pulses, all advancing on px_en ticks of the system clock.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter logic        SYNC_POL = DEF_SYNC_POL,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          px_en,
    input  logic          run,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          frame_start,
    output logic          line_end
);

    scan_state_t state_q, state_d;
    logic        frame_start_q, frame_start_d;
    logic        line_end_q, line_end_d;
    logic        axis_clr, h_step, v_step;
    logic        h_wrap, v_wrap;
    logic        h_in_sync, v_in_sync, h_in_active, v_in_active;
    logic [1:0]  h_phase_unused, v_phase_unused;

    // Dropping run aborts the frame on the next edge regardless of px_en.
    assign axis_clr = ~run;
    assign h_step   = (state_q == SCAN) && run && px_en;
    assign v_step   = h_step && h_wrap;

    vga_axis_timing #(
        .A_LEN (H_ACTIVE),
        .F_LEN (H_FRONT),
        .S_LEN (H_SYNC),
        .B_LEN (H_BACK),
        .CW    (CW)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .clr       (axis_clr),
        .step      (h_step),
        .cnt       (h_cnt),
        .phase     (h_phase_unused),
        .wrap      (h_wrap),
        .in_sync   (h_in_sync),
        .in_active (h_in_active)
    );

    vga_axis_timing #(
        .A_LEN (V_ACTIVE),
        .F_LEN (V_FRONT),
        .S_LEN (V_SYNC),
        .B_LEN (V_BACK),
        .CW    (CW)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .clr       (axis_clr),
        .step      (v_step),
        .cnt       (v_cnt),
        .phase     (v_phase_unused),
        .wrap      (v_wrap),
        .in_sync   (v_in_sync),
        .in_active (v_in_active)
    );

    // Next-state and marker pulses; entering SCAN lands on (0,0) and counts as a frame start.
    always_comb begin
        state_d       = state_q;
        frame_start_d = 1'b0;
        line_end_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (px_en && run) begin
                    state_d       = SCAN;
                    frame_start_d = 1'b1;
                end
            end
            SCAN: begin
                if (!run) begin
                    state_d = IDLE;
                end else begin
                    line_end_d    = h_step && h_wrap;
                    frame_start_d = h_step && h_wrap && v_wrap;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_start_q <= frame_start_d;
            line_end_q    <= line_end_d;
        end
    end

    // Level outputs are decodes of flops that change on the same edge as the counters.
    assign video_on    = (state_q == SCAN) && h_in_active && v_in_active;
    assign hsync       = h_in_sync ^ ~SYNC_POL;
    assign vsync       = v_in_sync ^ ~SYNC_POL;
    assign frame_start = frame_start_q;
    assign line_end    = line_end_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench: a behavioural scan model queues expected outputs per clock for a
// default 640x480 instance and a tiny-mode instance with active-high syncs.
module tb_vga_timing_ctrl;

    typedef struct {
        bit scan;
        int h;
        int v;
        bit fs;
        bit le;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pa = 1'b0, ra = 1'b1, pb = 1'b0, rb = 1'b1;

    logic       hsync_a, vsync_a, von_a, fs_a, le_a;
    logic [9:0] hc_a, vc_a;
    logic       hsync_b, vsync_b, von_b, fs_b, le_b;
    logic [3:0] hc_b, vc_b;

    logic [24:0] obs_a, obs_b;
    logic [24:0] q_a[$];
    logic [24:0] q_b[$];

    mdl_t ma, mb;
    int   n_cmp = 0;
    int   n_bad = 0;

    bit   meas_en = 1'b0;
    int   tk_a = 0, tk_b = 0;
    int   last_le_a = -1, last_fs_b = -1;
    int   cnt_von = 0, cnt_hs = 0;
    bit   found;

    always #5 clk = ~clk;

    vga_timing_ctrl u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .px_en       (pa),
        .run         (ra),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .video_on    (von_a),
        .h_cnt       (hc_a),
        .v_cnt       (vc_a),
        .frame_start (fs_a),
        .line_end    (le_a)
    );

    vga_timing_ctrl #(
        .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
        .V_ACTIVE (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .SYNC_POL (1'b1), .CW (4)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .px_en       (pb),
        .run         (rb),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .video_on    (von_b),
        .h_cnt       (hc_b),
        .v_cnt       (vc_b),
        .frame_start (fs_b),
        .line_end    (le_b)
    );

    assign obs_a = {hsync_a, vsync_a, von_a, fs_a, le_a, hc_a, vc_a};
    assign obs_b = {hsync_b, vsync_b, von_b, fs_b, le_b, 6'd0, hc_b, 6'd0, vc_b};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.scan = 1'b0; n.h = 0; n.v = 0; n.fs = 1'b0; n.le = 1'b0;
        return n;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input bit r, input bit px, input bit rn,
                                      input int ht, input int vt);
        mdl_t n;
        n    = m;
        n.fs = 1'b0;
        n.le = 1'b0;
        if (r) begin
            n = mdl_reset();
        end else if (!m.scan) begin
            if (px && rn) begin
                n.scan = 1'b1;
                n.fs   = 1'b1;
            end
        end else if (!rn) begin
            n = mdl_reset();
        end else if (px) begin
            if (m.h == ht - 1) begin
                n.h  = 0;
                n.le = 1'b1;
                if (m.v == vt - 1) begin
                    n.v  = 0;
                    n.fs = 1'b1;
                end else begin
                    n.v = m.v + 1;
                end
            end else begin
                n.h = m.h + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [24:0] mdl_out(input mdl_t m, input int ha, input int hf, input int hs,
                                            input int va, input int vf, input int vs, input bit pol);
        bit h_on, v_on, von;
        h_on = m.scan && (m.h >= ha + hf) && (m.h < ha + hf + hs);
        v_on = m.scan && (m.v >= va + vf) && (m.v < va + vf + vs);
        von  = m.scan && (m.h < ha) && (m.v < va);
        return {(h_on ? pol : !pol), (v_on ? pol : !pol), von, m.fs, m.le, 10'(m.h), 10'(m.v)};
    endfunction

    function automatic logic [24:0] exp_a(input mdl_t m);
        return mdl_out(m, 640, 16, 96, 480, 10, 2, 1'b0);
    endfunction

    function automatic logic [24:0] exp_b(input mdl_t m);
        return mdl_out(m, 4, 1, 1, 2, 1, 1, 1'b1);
    endfunction

    // One clock: drive at negedge, queue model expectations, compare just after posedge.
    task automatic tick(input bit r, input bit p_a, input bit r_a, input bit p_b, input bit r_b);
        @(negedge clk);
        rst = r; pa = p_a; ra = r_a; pb = p_b; rb = r_b;
        ma = mdl_next(ma, r, p_a, r_a, 800, 525);
        mb = mdl_next(mb, r, p_b, r_b, 7, 5);
        q_a.push_back(exp_a(ma));
        q_b.push_back(exp_b(mb));
        @(posedge clk);
        #1;
        check("scan_a", obs_a, q_a.pop_front());
        check("scan_b", obs_b, q_b.pop_front());
        if (p_a) tk_a++;
        if (p_b) tk_b++;
        if (meas_en) begin
            if (p_a && le_a) begin
                if (last_le_a >= 0) check("line_period_a", tk_a - last_le_a, 800);
                last_le_a = tk_a;
            end
            if (p_b && fs_b) begin
                if (last_fs_b >= 0) check("frame_period_b", tk_b - last_fs_b, 35);
                last_fs_b = tk_b;
            end
            if (p_a && von_a && vc_a == 10'd1) cnt_von++;
            if (p_a && !hsync_a && vc_a == 10'd1) cnt_hs++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();

        // Reset held while run=1 and px_en toggles.
        for (int i = 0; i < 6; i++) tick(1'b1, i[0], 1'b1, i[0], 1'b1);

        // Line timing on the default instance (px_en every 2nd clk); tiny instance free-runs.
        meas_en = 1'b1;
        for (int i = 0; i < 3400; i++) tick(1'b0, i[0], 1'b1, 1'b1, 1'b1);
        meas_en = 1'b0;
        check("video_on_ticks_line1", cnt_von, 640);
        check("hsync_ticks_line1", cnt_hs, 96);

        // Stall at column 700.
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            if (ma.h == 700) found = 1'b1;
        end
        check("reach_col_700", found, 1);
        for (int k = 0; k < 50; k++) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("resume_col_701", hc_a, 701);

        // Abort the default instance mid-line, then restart.
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            if (ma.h == 300) found = 1'b1;
        end
        check("reach_col_300", found, 1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("abort_blank_a", obs_a, 25'h1800000);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("restart_fs_a", fs_a, 1);

        // Abort the tiny instance at (2,3) with px_en still high.
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            if (mb.h == 2 && mb.v == 3) found = 1'b1;
        end
        check("reach_b_2_3", found, 1);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("abort_blank_b", obs_b, 25'h0);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("restart_fs_b", fs_b, 1);
        for (int k = 0; k < 40; k++) tick(1'b0, 1'b1, 1'b1, k[0], 1'b1);

        // Asynchronous reset mid-scan, between clock edges.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_a", obs_a, 25'h1800000);
        check("async_rst_b", obs_b, 25'h0);
        ma = mdl_reset();
        mb = mdl_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
